// File: rtl/gfx_rop_wbuf.sv
// Posted-write buffer between the ROP master port and the VRAM arbiter.
// In-order circular queue with tail-entry write merging and no fall-through.
module gfx_rop_wbuf #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rop_write,
  input  logic [ADDR_W-1:0]            rop_address,
  input  logic [DATA_W-1:0]            rop_writedata,
  output logic                         rop_waitrequest,
  output logic                         vram_write,
  output logic [ADDR_W-1:0]            vram_address,
  output logic [DATA_W-1:0]            vram_writedata,
  input  logic                         vram_waitrequest,
  output logic                         wbuf_idle,
  output logic [$clog2(DEPTH+1)-1:0]   wbuf_level
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head, tail, last;
  logic [CW-1:0]     count;
  logic              accept, issue, merge, push, pop;

  assign rop_waitrequest = (count == CW'(DEPTH));
  assign vram_write      = (count != '0);
  assign wbuf_idle       = (count == '0);
  assign wbuf_level      = count;
  assign vram_address    = addr_q[head];
  assign vram_writedata  = data_q[head];

  assign accept = rop_write && !rop_waitrequest;
  assign issue  = vram_write && !vram_waitrequest;
  assign last   = tail - 1'b1;
  // Only entries behind the head may merge: the head may already be on the bus.
  assign merge  = accept && (count >= CW'(2)) && (rop_address == addr_q[last]);
  assign push   = accept && !merge;
  assign pop    = issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry contents need no reset; count gates their visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= rop_address;
      data_q[tail] <= rop_writedata;
    end else if (merge) begin
      data_q[last] <= rop_writedata;
    end
  end
endmodule
